// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               bus FSM state encoding, line/beat geometry, decode window
//               width and the Sysbus read-request tag fields.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Bus-side fetch FSM, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACTIVE = 2'd3
  } fetch_state_t;

  localparam int LINE_BEATS         = 8;   // 64-bit beats per 64-byte line
  localparam int BEAT_BYTES         = 8;   // bytes carried by one beat
  localparam int FETCH_WINDOW_BYTES = 15;  // longest x86 instruction

  // Sysbus tag fields: {READ, MEMORY, 8'b0}
  localparam logic        BUS_READ         = 1'b1;
  localparam logic [3:0]  BUS_MEMORY       = 4'b0001;
  localparam logic [12:0] BUS_TAG_READ_MEM = {BUS_READ, BUS_MEMORY, 8'h00};

endpackage
`default_nettype wire

// File: rtl/fetch_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_byte_buffer
// Description : Circular byte store for the fetch stage. One 8-byte aligned
//               write slot per cycle, and a WINDOW_BYTES-wide read window
//               starting at any byte index that wraps past the buffer end.
//               Contains no pointer logic; the owner supplies indices.
// Ports       : clk        clock
//               wr_en      write one beat this cycle
//               wr_slot    8-byte slot index of the write
//               wr_data    beat data, byte 0 in [7:0]
//               rd_idx     byte index of window byte 0
//               rd_window  window, byte k at [8k+:8]
// Revision    : 1.0  initial release
// ============================================================================
module fetch_byte_buffer
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES    = 128,
  parameter int WINDOW_BYTES = FETCH_WINDOW_BYTES
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [$clog2(BUF_BYTES)-4:0]    wr_slot,
  input  logic [63:0]                     wr_data,
  input  logic [$clog2(BUF_BYTES)-1:0]    rd_idx,
  output logic [8*WINDOW_BYTES-1:0]       rd_window
);

  localparam int IDX_W = $clog2(BUF_BYTES);

  logic [7:0] r_mem [BUF_BYTES];

  // Storage needs no reset: bytes are only visible once the pointers say so.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        r_mem[{wr_slot, 3'(j)}] <= wr_data[8*j +: 8];
      end
    end
  end

  // Index arithmetic is IDX_W bits wide, so rd_idx + k wraps to the
  // buffer start on its own.
  generate
    for (genvar k = 0; k < WINDOW_BYTES; k++) begin : g_win
      assign rd_window[8*k +: 8] = r_mem[rd_idx + IDX_W'(k)];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues 64-byte line reads on
//               Sysbus, absorbs the 8 response beats into a circular byte
//               buffer and presents a WINDOW_BYTES window at the current RIP
//               to the decoder. Handles the misaligned start (skipped beats
//               and bytes), decoder consumption and redirect with discard of
//               the line still outstanding on the bus.
// Build macro : FETCH_PERF_EN  adds perf_lines / perf_starve counters.
// Ports       : clk, reset        clock, synchronous active-high reset
//               entry             start RIP, sampled while reset=1
//               redirect_valid    flush and refetch from redirect_rip
//               redirect_rip      new RIP
//               reqcyc/req/reqtag bus read request, held until reqack
//               reqack            request accepted
//               respcyc/resp      response beat, byte 0 in resp[7:0]
//               respack           response accept (= respcyc)
//               win_valid         window holds WINDOW_BYTES valid bytes
//               win_bytes         window, byte k at [8k+:8]
//               win_rip           RIP of window byte 0
//               consume_bytes     bytes retired this cycle
//               perf_lines        (FETCH_PERF_EN) lines completed
//               perf_starve       (FETCH_PERF_EN) starved cycles
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES    = 128,
  parameter int LINE_BYTES   = 64,
  parameter int WINDOW_BYTES = FETCH_WINDOW_BYTES,
  parameter int TAG_W        = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_rip,
  output logic                      reqcyc,
  output logic [63:0]               req,
  output logic [TAG_W-1:0]          reqtag,
  input  logic                      reqack,
  input  logic                      respcyc,
  input  logic [63:0]               resp,
  output logic                      respack,
  output logic                      win_valid,
  output logic [8*WINDOW_BYTES-1:0] win_bytes,
  output logic [63:0]               win_rip,
  input  logic [3:0]                consume_bytes
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_lines,
  output logic [31:0]               perf_starve
`endif
);

  // Pointers carry one extra bit so that full (occ == BUF_BYTES) and empty
  // are distinguishable.
  localparam int IDX_W = $clog2(BUF_BYTES);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [63:0]       c_line_mask = ~64'(LINE_BYTES - 1);
  localparam logic [PTR_W-1:0]  c_room_max  = PTR_W'(BUF_BYTES - LINE_BYTES);
  localparam logic [PTR_W-1:0]  c_win_min   = PTR_W'(WINDOW_BYTES);
  localparam logic [2:0]        c_last_beat = 3'(LINE_BEATS - 1);
  localparam logic [TAG_W-1:0]  c_read_tag  = TAG_W'(BUS_TAG_READ_MEM);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  fetch_state_t     r_state;
  logic [63:0]      r_req_addr;   // address of the request on the bus
  logic [63:0]      r_fetch_rip;  // next line to request
  logic [63:0]      r_win_rip;
  logic [PTR_W-1:0] r_fill_ptr;
  logic [PTR_W-1:0] r_dec_ptr;
  logic [2:0]       r_beat_cnt;
  logic [2:0]       r_beat_skip;
  logic [2:0]       r_byte_skip;
  logic             r_discard;    // line on the bus predates a redirect
  logic             r_primed;     // dec_ptr already aligned to first byte

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] w_occ;
  logic             w_win_valid;
  logic             w_room;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_keep_beat;
  logic [3:0]       w_consume;

  assign w_occ       = r_fill_ptr - r_dec_ptr;
  assign w_win_valid = (w_occ >= c_win_min);
  assign w_room      = (w_occ <= c_room_max);

  // Beats are only legal in WAIT (beat 0) and ACTIVE.
  assign w_beat      = respcyc && ((r_state == ST_WAIT) || (r_state == ST_ACTIVE));
  assign w_last_beat = w_beat && (r_beat_cnt == c_last_beat);

  // Redirect wins over the beat write; discarded lines and beats ahead of
  // the starting RIP are never stored.
  assign w_keep_beat = w_beat && !r_discard && !redirect_valid &&
                       (r_beat_cnt >= r_beat_skip);

  assign w_consume   = w_win_valid ? consume_bytes : 4'd0;

  // --------------------------------------------------------------------------
  // Bus FSM, pointers and RIP tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= '0;
      r_fetch_rip <= entry & c_line_mask;
      r_win_rip   <= entry;
      r_fill_ptr  <= '0;
      r_dec_ptr   <= '0;
      r_beat_cnt  <= '0;
      r_beat_skip <= entry[5:3];
      r_byte_skip <= entry[2:0];
      r_discard   <= 1'b0;
      r_primed    <= 1'b0;
    end else begin
      // The FSM keeps following the bus even across a redirect: a request
      // once raised is held to reqack and its 8 beats are always drained.
      case (r_state)
        ST_IDLE: begin
          if (w_room && !redirect_valid) begin
            r_state    <= ST_REQ;
            r_req_addr <= r_fetch_rip;
          end
        end
        ST_REQ: begin
          if (reqack) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (respcyc) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_last_beat) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 3'd1;
      end

      // End of line. A discarded line leaves fetch_rip and the skips alone:
      // they already describe the redirect target.
      if (w_last_beat) begin
        if (r_discard) begin
          r_discard <= 1'b0;
        end else begin
          r_fetch_rip <= r_fetch_rip + 64'(LINE_BYTES);
          r_beat_skip <= 3'd0;
          r_byte_skip <= 3'd0;
        end
      end

      if (redirect_valid) begin
        r_fetch_rip <= redirect_rip & c_line_mask;
        r_beat_skip <= redirect_rip[5:3];
        r_byte_skip <= redirect_rip[2:0];
        // A redirect landing on the final beat finishes that line now, so
        // there is nothing left to discard.
        r_discard   <= (r_state != ST_IDLE) && !w_last_beat;
        r_fill_ptr  <= '0;
        r_dec_ptr   <= '0;
        r_primed    <= 1'b0;
        r_win_rip   <= redirect_rip;
      end else begin
        if (w_keep_beat) begin
          r_fill_ptr <= r_fill_ptr + PTR_W'(BEAT_BYTES);
        end
        // First stored beat: skip the bytes below the start RIP. The window
        // is empty at this point, so no consume can collide with it.
        if (w_keep_beat && !r_primed) begin
          r_dec_ptr <= r_fill_ptr + PTR_W'(r_byte_skip);
          r_primed  <= 1'b1;
        end else begin
          r_dec_ptr <= r_dec_ptr + PTR_W'(w_consume);
        end
        r_win_rip <= r_win_rip + 64'(w_consume);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte storage
  // --------------------------------------------------------------------------
  fetch_byte_buffer #(
    .BUF_BYTES    (BUF_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_buf (
    .clk       (clk),
    .wr_en     (w_keep_beat),
    .wr_slot   (r_fill_ptr[IDX_W-1:3]),
    .wr_data   (resp),
    .rd_idx    (r_dec_ptr[IDX_W-1:0]),
    .rd_window (win_bytes)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign reqcyc    = (r_state == ST_REQ);
  assign req       = reqcyc ? r_req_addr : 64'd0;
  assign reqtag    = reqcyc ? c_read_tag : '0;
  assign respack   = respcyc;
  assign win_valid = w_win_valid;
  assign win_rip   = r_win_rip;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_lines;
  logic [31:0] r_perf_starve;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_lines  <= '0;
      r_perf_starve <= '0;
    end else begin
      if (w_last_beat) begin
        r_perf_lines <= r_perf_lines + 32'd1;
      end
      if (!w_win_valid && !redirect_valid) begin
        r_perf_starve <= r_perf_starve + 32'd1;
      end
    end
  end

  assign perf_lines  = r_perf_lines;
  assign perf_starve = r_perf_starve;
`endif

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_consume_range : assert property (@(posedge clk) disable iff (reset)
    !(w_win_valid && ({1'b0, consume_bytes} > 5'(WINDOW_BYTES))))
    else $fatal(1, "fetch_unit: consume_bytes exceeds window width");

  a_resp_state : assert property (@(posedge clk) disable iff (reset)
    !(respcyc && ((r_state == ST_IDLE) || (r_state == ST_REQ))))
    else $fatal(1, "fetch_unit: response beat with no request outstanding");

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit. A small Sysbus responder
//               acks requests after a programmable delay, returns 8 beats
//               whose bytes are a fixed function of address, and can fire a
//               redirect at a chosen point of a transaction.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  entry;
  logic         redirect_valid;
  logic [63:0]  redirect_rip;
  logic         reqcyc;
  logic [63:0]  req;
  logic [12:0]  reqtag;
  logic         reqack;
  logic         respcyc;
  logic [63:0]  resp;
  logic         respack;
  logic         win_valid;
  logic [119:0] win_bytes;
  logic [63:0]  win_rip;
  logic [3:0]   consume_bytes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_rip   (redirect_rip),
    .reqcyc         (reqcyc),
    .req            (req),
    .reqtag         (reqtag),
    .reqack         (reqack),
    .respcyc        (respcyc),
    .resp           (resp),
    .respack        (respack),
    .win_valid      (win_valid),
    .win_bytes      (win_bytes),
    .win_rip        (win_rip),
    .consume_bytes  (consume_bytes)
  );

  // ---------------------------------------------------------------- memory
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] + 8'(a[15:8] * 8'd3);
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = mem_byte(line + 64'(b*8 + j));
    return v;
  endfunction

  function automatic logic [119:0] exp_window(input logic [63:0] rip);
    logic [119:0] v;
    for (int k = 0; k < 15; k++) v[8*k +: 8] = mem_byte(rip + 64'(k));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------- responder
  int          ack_delay  = 0;
  int          wait_cnt   = 0;
  int          beat_idx   = 0;
  int          drop_cnt   = 0;
  bit          pending    = 0;
  int          redir_mode = 0;   // 0 off, 1 at beat redir_n, 2 at REQ cycle redir_n
  int          redir_n    = 0;
  logic [63:0] redir_target = '0;
  logic [12:0] last_tag   = '0;
  logic [63:0] line_q[$];
  logic [63:0] req_log[$];

  initial begin
    reqack = 0; respcyc = 0; resp = '0; redirect_valid = 0; redirect_rip = '0;
    forever begin
      @(negedge clk);
      reqack = 0; respcyc = 0; resp = '0; redirect_valid = 0;
      if (reset) begin
        line_q.delete(); beat_idx = 0; wait_cnt = 0; pending = 0;
      end else begin
        if (pending && !reqcyc) drop_cnt++;
        pending = 0;
        if (reqcyc) begin
          if (redir_mode == 2 && wait_cnt == redir_n) begin
            redirect_valid = 1; redirect_rip = redir_target; redir_mode = 0;
          end
          if (wait_cnt >= ack_delay) begin
            reqack = 1; req_log.push_back(req); line_q.push_back(req);
            last_tag = reqtag; wait_cnt = 0;
          end else begin
            wait_cnt++; pending = 1;
          end
        end else if (line_q.size() > 0) begin
          respcyc = 1;
          resp = beat_data(line_q[0], beat_idx);
          if (redir_mode == 1 && beat_idx == redir_n) begin
            redirect_valid = 1; redirect_rip = redir_target; redir_mode = 0;
          end
          beat_idx++;
          if (beat_idx == 8) begin
            beat_idx = 0;
            void'(line_q.pop_front());
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- helpers
  function automatic logic [63:0] get_req(input int i);
    return (req_log.size() > i) ? req_log[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic hold_reset(input logic [63:0] e, input int dly);
    @(negedge clk);
    reset = 1; entry = e; consume_bytes = 0;
    repeat (3) @(negedge clk);
    req_log.delete(); drop_cnt = 0; redir_mode = 0; ack_delay = dly;
  endtask

  task automatic do_reset(input logic [63:0] e, input int dly);
    hold_reset(e, dly);
    reset = 0;
  endtask

  task automatic wait_reqs(input int n, input int budget, input string tag);
    for (int c = 0; c < budget && req_log.size() < n; c++) @(negedge clk);
    chk(tag, 128'(req_log.size() >= n), 1);
  endtask

  task automatic wait_win(input int budget, input string tag);
    for (int c = 0; c < budget && !win_valid; c++) @(negedge clk);
    chk(tag, 128'(win_valid), 1);
  endtask

  task automatic wait_bus_idle(input int budget);
    for (int c = 0; c < budget && line_q.size() != 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  // Retire n bytes in chunks of up to 15 while the window is valid.
  task automatic consume_total(input int n);
    int left = n;
    for (int c = 0; c < 200 && left > 0; c++) begin
      @(negedge clk);
      if (win_valid) begin
        consume_bytes = 4'((left > 15) ? 15 : left);
        left -= (left > 15) ? 15 : left;
      end else begin
        consume_bytes = 0;
      end
    end
    @(negedge clk);
    consume_bytes = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ------------------------------------------------------------------ main
  logic [63:0] exp_rip;

  initial begin
    reset = 1; entry = '0; consume_bytes = 0;

    // 1. misaligned entry, reset values
    hold_reset(64'h1000_0013, 0);
    chk("rst_reqcyc", 128'(reqcyc), 0);
    chk("rst_req", req, 0);
    chk("rst_reqtag", reqtag, 0);
    chk("rst_winvalid", 128'(win_valid), 0);
    chk("rst_winrip", win_rip, 64'h1000_0013);
    reset = 0;
    wait_reqs(1, 20, "t1_req_seen");
    chk("t1_req", get_req(0), 64'h1000_0000);
    chk("t1_tag", last_tag, 13'h1100);
    wait_win(40, "t1_winvalid");
    chk("t1_winrip", win_rip, 64'h1000_0013);
    chk("t1_byte0", win_bytes[7:0], 8'h13);
    chk("t1_window", win_bytes, exp_window(64'h1000_0013));

    // 2. aligned streaming, 3-cycle ack delay
    do_reset(64'h4000, 3);
    exp_rip = 64'h4000;
    for (int c = 0; c < 600 && req_log.size() < 3; c++) begin
      @(negedge clk);
      if (win_valid) begin
        chk("t2_window", win_bytes, exp_window(exp_rip));
        consume_bytes = 4'd15;
        exp_rip += 64'd15;
      end else begin
        consume_bytes = 0;
      end
    end
    @(negedge clk);
    consume_bytes = 0;
    chk("t2_req_seen", 128'(req_log.size() >= 3), 1);
    chk("t2_req0", get_req(0), 64'h4000);
    chk("t2_req1", get_req(1), 64'h4040);
    chk("t2_req2", get_req(2), 64'h4080);
    chk("t2_reqcyc_held", 128'(drop_cnt), 0);
    chk("t2_winrip", win_rip, exp_rip);

    // 3. decoder stall throttles requests
    do_reset(64'h8000, 0);
    wait_reqs(2, 60, "t3_req2_seen");
    wait_bus_idle(60);
    repeat (20) @(negedge clk);
    chk("t3_hold_occ128", 128'(req_log.size()), 2);
    chk("t3_rip0", win_rip, 64'h8000);
    consume_total(1);
    repeat (20) @(negedge clk);
    chk("t3_hold_occ127", 128'(req_log.size()), 2);
    chk("t3_rip1", win_rip, 64'h8001);
    consume_total(62);
    repeat (20) @(negedge clk);
    chk("t3_hold_occ65", 128'(req_log.size()), 2);
    consume_total(1);
    wait_reqs(3, 40, "t3_req3_seen");
    chk("t3_req2", get_req(2), 64'h8080);
    chk("t3_rip64", win_rip, 64'h8040);

    // 4. window wrapping across the buffer end (dec index 120)
    wait_bus_idle(60);
    consume_total(56);
    chk("t4_winvalid", 128'(win_valid), 1);
    chk("t4_winrip", win_rip, 64'h8078);
    chk("t4_byte0", win_bytes[7:0], 8'hF8);
    chk("t4_byte8", win_bytes[71:64], 8'h00);
    chk("t4_window", win_bytes, exp_window(64'h8078));

    // 5. redirect during ACTIVE beat 3
    do_reset(64'h1000, 0);
    redir_mode = 1; redir_n = 3; redir_target = 64'h2008;
    wait_reqs(2, 80, "t5_req2_seen");
    chk("t5_req0", get_req(0), 64'h1000);
    chk("t5_req1", get_req(1), 64'h2000);
    chk("t5_flushed", 128'(win_valid), 0);
    wait_win(40, "t5_winvalid");
    chk("t5_winrip", win_rip, 64'h2008);
    chk("t5_byte0", win_bytes[7:0], 8'h68);
    chk("t5_window", win_bytes, exp_window(64'h2008));
    wait_reqs(3, 40, "t5_req3_seen");
    chk("t5_req2", get_req(2), 64'h2040);

    // 6. redirect while REQ is waiting for ack
    do_reset(64'h3000, 3);
    redir_mode = 2; redir_n = 1; redir_target = 64'h5020;
    wait_reqs(2, 80, "t6_req2_seen");
    chk("t6_req0", get_req(0), 64'h3000);
    chk("t6_req1", get_req(1), 64'h5000);
    chk("t6_reqcyc_held", 128'(drop_cnt), 0);
    chk("t6_flushed", 128'(win_valid), 0);
    wait_win(40, "t6_winvalid");
    chk("t6_winrip", win_rip, 64'h5020);
    chk("t6_byte0", win_bytes[7:0], 8'h10);
    chk("t6_window", win_bytes, exp_window(64'h5020));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
